corr_count_multi: RTL and testbench

- N-channel windowed correlation counter: N_CH probe bits x[k] against one shared reference bit y; per-window weighted counts of X[k], Y, X[k]&Y and X[k]^Y.
- Window timing is generated internally, with rectangular or logdrop weighting selectable per window.
- Completed-window results are double-buffered into a result register with a valid/ready handshake, so counting continues without a gap.
- Sits between probe synchronisers and the correlator readout/bus interface.

---
 rtl/corr_pkg.sv | 19 +
 rtl/corr_weight_gen.sv | 92 +++++++++
 rtl/logdropWindow.sv | 32 +++
 rtl/corr_count_multi.sv | 167 ++++++++++++++++
 tb/tb_corr_count_multi.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared types and helpers for the windowed correlation counter
package corr_pkg;

    typedef enum logic [0:0] {
        SHAPE_RECT    = 1'b0,
        SHAPE_LOGDROP = 1'b1
    } shape_t;

    // Counter width: a full rectangular window sums to exactly half of full scale.
    function automatic int counter_w(input int time_w, input int incr_w);
        return time_w + incr_w - 1;
    endfunction

    // LSB position of channel k inside a flattened per-channel bus.
    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/corr_weight_gen.sv
// rtl/corr_weight_gen.sv - window timer, config latches and registered sample weight
module corr_weight_gen
    import corr_pkg::*;
#(
    parameter  int INCR_W    = 16,
    parameter  int TIME_W    = 8,
    localparam int COUNTER_W = counter_w(TIME_W, INCR_W),
    localparam int EW        = $clog2(TIME_W + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cg,
    input  logic [EW-1:0]        i_windowLengthExp,
    input  logic                 i_windowShape,
    input  logic                 i_restart,
    output logic [TIME_W-1:0]    o_t,
    output logic                 o_valid,
    output logic                 o_last,
    output logic [COUNTER_W-1:0] o_w
);

    localparam logic [INCR_W-1:0] LD_ONE = INCR_W'(1) << (INCR_W - 1);

    logic [TIME_W-1:0]    t_q, t_d;
    logic [EW-1:0]        e_q, e_d, e_in, e_eff, sh;
    shape_t               shape_q, shape_d, shape_eff;
    logic                 s1_valid_q, s1_valid_d;
    logic                 last_q, last_d;
    logic [COUNTER_W-1:0] w_q, w_d, rect_w, ld_w;
    logic [TIME_W-1:0]    len_mask, ld_t;
    logic [INCR_W-1:0]    ld_out;
    logic                 active;

    logdropWindow #(
        .DATA_W (INCR_W),
        .WINLEN (2 ** TIME_W)
    ) u_logdrop (
        .i_t (ld_t),
        .i_x (LD_ONE),
        .o_y (ld_out)
    );

    // Window config comes straight from the inputs at t==0, otherwise from the latches.
    always_comb begin
        e_in      = (i_windowLengthExp > EW'(TIME_W)) ? EW'(TIME_W) : i_windowLengthExp;
        e_eff     = (t_q == '0) ? e_in : e_q;
        shape_eff = (t_q == '0) ? shape_t'(i_windowShape) : shape_q;
        sh        = EW'(TIME_W) - e_eff;
        len_mask  = ~({TIME_W{1'b1}} << e_eff);
        active    = (e_eff != '0);
        ld_t      = t_q << sh;
        rect_w    = COUNTER_W'(1) << (int'(sh) + INCR_W - 2);
        ld_w      = COUNTER_W'(ld_out) << sh;
        w_d       = (shape_eff == SHAPE_LOGDROP) ? ld_w : rect_w;
        last_d    = (t_q == len_mask);
        e_d       = i_restart ? e_in : e_eff;
        shape_d   = i_restart ? shape_t'(i_windowShape) : shape_eff;
        s1_valid_d = active && !i_restart;
        if (i_restart || !active || last_d) begin
            t_d = '0;
        end else begin
            t_d = t_q + TIME_W'(1);
        end
    end

    // Timer, config latches and the stage-1 weight/last/valid registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            t_q        <= '0;
            e_q        <= '0;
            shape_q    <= SHAPE_RECT;
            s1_valid_q <= 1'b0;
            last_q     <= 1'b0;
            w_q        <= '0;
        end else if (i_cg) begin
            t_q        <= t_d;
            e_q        <= e_d;
            shape_q    <= shape_d;
            s1_valid_q <= s1_valid_d;
            last_q     <= last_d;
            w_q        <= w_d;
        end
    end

    assign o_t     = t_q;
    assign o_valid = s1_valid_q;
    assign o_last  = last_q;
    assign o_w     = w_q;

    a_w_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(w_q));

endmodule

// File: rtl/logdropWindow.sv
// rtl/logdropWindow.sv - halves the input once per leading one of the window time
module logdropWindow #(
    parameter  int DATA_W = 16,
    parameter  int WINLEN = 256,
    localparam int TW     = $clog2(WINLEN),
    localparam int NW     = $clog2(TW + 1)
) (
    input  logic [TW-1:0]     i_t,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);

    logic [NW-1:0] n_lead;
    logic          run;

    // Count leading ones of the time: first half full weight, then each
    // successive remaining half of the window drops the weight by 2x.
    always_comb begin
        n_lead = '0;
        run    = 1'b1;
        for (int i = TW - 1; i >= 0; i--) begin
            if (run && i_t[i]) begin
                n_lead = n_lead + NW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign o_y = i_x >> n_lead;

endmodule

// File: rtl/corr_count_multi.sv
// rtl/corr_count_multi.sv - N-channel windowed correlation counter with buffered results
module corr_count_multi
    import corr_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int INCR_W    = 16,
    parameter  int TIME_W    = 8,
    localparam int COUNTER_W = counter_w(TIME_W, INCR_W),
    localparam int EW        = $clog2(TIME_W + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cg,
    input  logic [N_CH-1:0]           i_x,
    input  logic                      i_y,
    input  logic [EW-1:0]             i_windowLengthExp,
    input  logic                      i_windowShape,
    input  logic                      i_restart,
    output logic [TIME_W-1:0]         o_t,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_overrun,
    output logic [N_CH*COUNTER_W-1:0] o_countX,
    output logic [COUNTER_W-1:0]      o_countY,
    output logic [N_CH*COUNTER_W-1:0] o_countIsect,
    output logic [N_CH*COUNTER_W-1:0] o_countSymdiff
);

    logic                 s1_valid, s1_last;
    logic [COUNTER_W-1:0] w;
    logic [COUNTER_W:0]   w_ext;
    logic [N_CH-1:0]      x_q;
    logic                 y_q;
    logic                 clr, load, xfer;
    logic                 valid_q, valid_d, overrun_q, overrun_d;
    logic [3*N_CH:0]      carry;

    corr_weight_gen #(
        .INCR_W (INCR_W),
        .TIME_W (TIME_W)
    ) u_weight (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_cg              (i_cg),
        .i_windowLengthExp (i_windowLengthExp),
        .i_windowShape     (i_windowShape),
        .i_restart         (i_restart),
        .o_t               (o_t),
        .o_valid           (s1_valid),
        .o_last            (s1_last),
        .o_w               (w)
    );

    // Stage-1 copy of the probe and reference bits, aligned with the weight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q <= '0;
            y_q <= 1'b0;
        end else if (i_cg) begin
            x_q <= i_x;
            y_q <= i_y;
        end
    end

    assign w_ext = {1'b0, w};
    assign clr   = i_restart || (s1_valid && s1_last);
    assign load  = s1_valid && s1_last && !i_restart;
    assign xfer  = valid_q && i_ready;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [COUNTER_W-1:0] cnt_x_q, cnt_i_q, cnt_s_q;
        logic [COUNTER_W-1:0] res_x_q, res_i_q, res_s_q;
        logic [COUNTER_W:0]   cnt_x_d, cnt_i_d, cnt_s_d;

        // Stage-2 accumulate: add the weight to each counter whose condition holds.
        always_comb begin
            cnt_x_d = {1'b0, cnt_x_q} + ((s1_valid && x_q[k]) ? w_ext : '0);
            cnt_i_d = {1'b0, cnt_i_q} + ((s1_valid && x_q[k] && y_q) ? w_ext : '0);
            cnt_s_d = {1'b0, cnt_s_q} + ((s1_valid && (x_q[k] ^ y_q)) ? w_ext : '0);
        end

        // Counters clear at window end/restart; results capture the final next-values.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_x_q <= '0;
                cnt_i_q <= '0;
                cnt_s_q <= '0;
                res_x_q <= '0;
                res_i_q <= '0;
                res_s_q <= '0;
            end else if (i_cg) begin
                if (clr) begin
                    cnt_x_q <= '0;
                    cnt_i_q <= '0;
                    cnt_s_q <= '0;
                end else begin
                    cnt_x_q <= cnt_x_d[COUNTER_W-1:0];
                    cnt_i_q <= cnt_i_d[COUNTER_W-1:0];
                    cnt_s_q <= cnt_s_d[COUNTER_W-1:0];
                end
                if (load) begin
                    res_x_q <= cnt_x_d[COUNTER_W-1:0];
                    res_i_q <= cnt_i_d[COUNTER_W-1:0];
                    res_s_q <= cnt_s_d[COUNTER_W-1:0];
                end
            end
        end

        assign carry[3*k]     = cnt_x_d[COUNTER_W];
        assign carry[3*k + 1] = cnt_i_d[COUNTER_W];
        assign carry[3*k + 2] = cnt_s_d[COUNTER_W];

        assign o_countX[ch_lsb(k, COUNTER_W) +: COUNTER_W]       = res_x_q;
        assign o_countIsect[ch_lsb(k, COUNTER_W) +: COUNTER_W]   = res_i_q;
        assign o_countSymdiff[ch_lsb(k, COUNTER_W) +: COUNTER_W] = res_s_q;
    end

    logic [COUNTER_W-1:0] cnt_y_q, res_y_q;
    logic [COUNTER_W:0]   cnt_y_d;

    assign cnt_y_d          = {1'b0, cnt_y_q} + ((s1_valid && y_q) ? w_ext : '0);
    assign carry[3*N_CH]    = cnt_y_d[COUNTER_W];

    // Shared reference counter and its result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_y_q <= '0;
            res_y_q <= '0;
        end else if (i_cg) begin
            cnt_y_q <= clr ? '0 : cnt_y_d[COUNTER_W-1:0];
            if (load) begin
                res_y_q <= cnt_y_d[COUNTER_W-1:0];
            end
        end
    end

    assign o_countY = res_y_q;

    // Result handshake: a load overrides a pending transfer; overwriting an
    // unconsumed result flags overrun until the next transfer or clean load.
    always_comb begin
        valid_d   = load || (valid_q && !xfer);
        overrun_d = overrun_q;
        if (load) begin
            overrun_d = valid_q && !xfer;
        end else if (xfer) begin
            overrun_d = 1'b0;
        end
    end

    // Handshake state register, frozen along with everything else under clock gating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (i_cg) begin
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;

    a_no_carry: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_cg |-> (carry == '0));

endmodule

// File: tb/tb_corr_count_multi.sv
// tb/tb_corr_count_multi.sv - directed self-checking bench for corr_count_multi
module tb_corr_count_multi;

    localparam int N_CH = 2;
    localparam int INCR_W = 4;
    localparam int TIME_W = 4;
    localparam int CW = 7;

    logic            clk;
    logic            rst_n;
    logic            cg;
    logic [1:0]      x_i;
    logic            y_i;
    logic [2:0]      e_i;
    logic            shape_i;
    logic            restart_i;
    logic            ready_i;
    logic [3:0]      t_o;
    logic            valid_o;
    logic            overrun_o;
    logic [13:0]     cx;
    logic [6:0]      cy;
    logic [13:0]     ci;
    logic [13:0]     cs;

    int n_checks;
    int n_fail;

    corr_count_multi #(
        .N_CH   (N_CH),
        .INCR_W (INCR_W),
        .TIME_W (TIME_W)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cg              (cg),
        .i_x               (x_i),
        .i_y               (y_i),
        .i_windowLengthExp (e_i),
        .i_windowShape     (shape_i),
        .i_restart         (restart_i),
        .o_t               (t_o),
        .o_valid           (valid_o),
        .i_ready           (ready_i),
        .o_overrun         (overrun_o),
        .o_countX          (cx),
        .o_countY          (cy),
        .o_countIsect      (ci),
        .o_countSymdiff    (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_counts(input string tag, input int x0, input int x1, input int yy,
                                 input int i0, input int i1, input int s0, input int s1);
        check_eq({tag, ".valid"}, valid_o, 1);
        check_eq({tag, ".x0"}, cx[6:0], x0);
        check_eq({tag, ".x1"}, cx[13:7], x1);
        check_eq({tag, ".y"}, cy, yy);
        check_eq({tag, ".i0"}, ci[6:0], i0);
        check_eq({tag, ".i1"}, ci[13:7], i1);
        check_eq({tag, ".s0"}, cs[6:0], s0);
        check_eq({tag, ".s1"}, cs[13:7], s1);
    endtask

    // Feeds one full window starting at t==0, then idles the timer with e=0.
    task automatic run_window(input logic [2:0] e, input logic shape,
                              input logic [15:0] x0v, input logic [15:0] x1v, input logic [15:0] yv);
        int len;
        len = 1 << e;
        e_i = e;
        shape_i = shape;
        for (int t = 0; t < len; t++) begin
            x_i = {x1v[t], x0v[t]};
            y_i = yv[t];
            check_eq("win.t", t_o, t);
            step();
        end
        e_i = 3'd0;
        x_i = 2'b00;
        y_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cg = 1'b1;
        x_i = 2'b00;
        y_i = 1'b0;
        e_i = 3'd0;
        shape_i = 1'b0;
        restart_i = 1'b0;
        ready_i = 1'b1;

        // Reset state
        step();
        step();
        check_eq("rst.t", t_o, 0);
        check_eq("rst.valid", valid_o, 0);
        check_eq("rst.overrun", overrun_o, 0);
        check_eq("rst.cx", cx, 0);
        check_eq("rst.cy", cy, 0);
        rst_n = 1'b1;
        step();
        step();
        check_eq("idle.t", t_o, 0);
        check_eq("idle.valid", valid_o, 0);

        // Rectangular e=2, all ones: weight 16 x 4 samples
        run_window(3'd2, 1'b0, 16'hF, 16'hF, 16'hF);
        check_eq("rect.early_valid", valid_o, 0);
        step();
        expect_counts("rect_ones", 64, 64, 64, 64, 64, 0, 0);
        step();
        check_eq("rect.pulse_fall", valid_o, 0);

        // Logdrop e=2, x0 only at t=0: weight 32
        run_window(3'd2, 1'b1, 16'h1, 16'h0, 16'h0);
        step();
        expect_counts("logdrop_t0", 32, 0, 0, 0, 0, 32, 0);
        step();

        // Logdrop e=2, weights 32,32,16,8; x0 all ones, y at t=0,2
        run_window(3'd2, 1'b1, 16'hF, 16'h0, 16'h5);
        step();
        expect_counts("logdrop_mix", 88, 0, 48, 48, 0, 40, 48);
        step();

        // Rectangular e=3, weight 8, mixed patterns
        run_window(3'd3, 1'b0, 16'hB2, 16'hFF, 16'hF0);
        step();
        expect_counts("rect_e3", 32, 64, 32, 24, 32, 16, 32);
        step();

        // Overrun: two results without consumption
        ready_i = 1'b0;
        run_window(3'd1, 1'b0, 16'h1, 16'h0, 16'h0);
        step();
        expect_counts("ovr_first", 32, 0, 0, 0, 0, 32, 0);
        check_eq("ovr.first_overrun", overrun_o, 0);
        step();
        step();
        check_eq("ovr.stable_x0", cx[6:0], 32);
        check_eq("ovr.stable_valid", valid_o, 1);
        run_window(3'd1, 1'b0, 16'h3, 16'h0, 16'h0);
        check_eq("ovr.pre_load_overrun", overrun_o, 0);
        step();
        check_eq("ovr.valid", valid_o, 1);
        check_eq("ovr.overrun", overrun_o, 1);
        check_eq("ovr.x0", cx[6:0], 64);
        ready_i = 1'b1;
        step();
        check_eq("ovr.valid_clr", valid_o, 0);
        check_eq("ovr.overrun_clr", overrun_o, 0);

        // Mid-window e change: 4-sample window, then 8-sample window
        e_i = 3'd2;
        shape_i = 1'b0;
        x_i = 2'b01;
        y_i = 1'b0;
        step();
        e_i = 3'd3;
        step();
        step();
        check_eq("echg.t3", t_o, 3);
        step();
        check_eq("echg.wrap3", t_o, 0);
        step();
        check_eq("echg.t1", t_o, 1);
        check_eq("echg.w1_valid", valid_o, 1);
        check_eq("echg.w1_x0", cx[6:0], 64);
        for (int i = 0; i < 6; i++) step();
        check_eq("echg.t7", t_o, 7);
        check_eq("echg.no_early", valid_o, 0);
        step();
        check_eq("echg.wrap7", t_o, 0);
        e_i = 3'd0;
        x_i = 2'b00;
        step();
        check_eq("echg.w2_valid", valid_o, 1);
        check_eq("echg.w2_x0", cx[6:0], 64);
        step();

        // Restart at t=2 discards the window
        e_i = 3'd2;
        x_i = 2'b01;
        step();
        step();
        check_eq("rs.t2", t_o, 2);
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        check_eq("rs.t0", t_o, 0);
        check_eq("rs.no_result", valid_o, 0);
        run_window(3'd2, 1'b0, 16'hF, 16'h0, 16'h0);
        check_eq("rs.no_stray", valid_o, 0);
        step();
        expect_counts("restart", 64, 0, 0, 0, 0, 64, 0);
        step();

        // Clock gate held 5 cycles mid-window
        e_i = 3'd2;
        shape_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (t == 2) begin
                cg = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    x_i = 2'($urandom);
                    y_i = 1'($urandom);
                    restart_i = 1'b0;
                    step();
                    check_eq("cg.t_frozen", t_o, 2);
                end
                cg = 1'b1;
            end
            x_i = 2'b01;
            y_i = t[0];
            check_eq("cg.t", t_o, t);
            step();
        end
        e_i = 3'd0;
        x_i = 2'b00;
        y_i = 1'b0;
        step();
        expect_counts("cg", 64, 0, 32, 32, 0, 32, 32);
        cg = 1'b0;
        step();
        step();
        check_eq("cg.hs_frozen", valid_o, 1);
        cg = 1'b1;
        step();
        check_eq("cg.hs_resume", valid_o, 0);

        // Asynchronous reset mid-window with a pending result
        ready_i = 1'b0;
        run_window(3'd1, 1'b0, 16'h3, 16'h3, 16'h3);
        step();
        check_eq("ar.pre_valid", valid_o, 1);
        e_i = 3'd2;
        x_i = 2'b11;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar.t", t_o, 0);
        check_eq("ar.valid", valid_o, 0);
        check_eq("ar.overrun", overrun_o, 0);
        check_eq("ar.cx", cx, 0);
        check_eq("ar.cy", cy, 0);
        check_eq("ar.ci", ci, 0);
        check_eq("ar.cs", cs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
